// File: rtl/demo_scene_sequencer_if.sv
// demo_scene_sequencer_if: frame/song inputs and layer/fade outputs of the scene sequencer.
// Optional force_en/force_scene signals exist only when SEQ_FORCE_EN is defined.
interface demo_scene_sequencer_if;
    logic       frame_start;
    logic [7:0] songpos;
`ifdef SEQ_FORCE_EN
    logic       force_en;
    logic [2:0] force_scene;
`endif
    logic [2:0] scene_id;
    logic       starfield_en;
    logic       scroller_en;
    logic       plane_en;
    logic       scope_en;
    logic       tileflash_en;
    logic [5:0] fade_level;
    logic [7:0] scene_frames;
    logic       busy;

    modport master (
`ifdef SEQ_FORCE_EN
        output force_en, force_scene,
`endif
        output frame_start, songpos,
        input  scene_id, starfield_en, scroller_en, plane_en, scope_en, tileflash_en,
        input  fade_level, scene_frames, busy
    );

    modport slave (
`ifdef SEQ_FORCE_EN
        input  force_en, force_scene,
`endif
        input  frame_start, songpos,
        output scene_id, starfield_en, scroller_en, plane_en, scope_en, tileflash_en,
        output fade_level, scene_frames, busy
    );
endinterface

// File: rtl/demo_scene_sequencer.sv
// demo_scene_sequencer: maps song position to a scene and sequences fade out -> switch -> fade in,
// updating only on frame_start. Define SEQ_FORCE_EN to let force_en/force_scene override the target.
module demo_scene_sequencer #(
    parameter int FADE_STEP = 4,
    parameter int FADE_MAX  = 63
) (
    input logic                    clk48,
    input logic                    rst_n,
    demo_scene_sequencer_if.slave  seq
);
    typedef enum logic [1:0] {RUN, FADE_OUT, SWITCH, FADE_IN} state_t;

    localparam logic [6:0] STEP = 7'(FADE_STEP);
    localparam logic [6:0] MAX  = 7'(FADE_MAX);

    state_t     state_q, state_d;
    logic [2:0] scene_q, scene_d, target;
    logic [4:0] en_q, en_d;
    logic [5:0] fade_q, fade_d;
    logic [7:0] frames_q, frames_d;
    logic       busy_q, busy_d;
    logic [6:0] fade_up;
    logic       fade_low, fading_out;
    logic       unused_songpos;

    // Layer enables per scene: {tileflash, scope, plane, scroller, starfield}
    function automatic logic [4:0] scene_en(input logic [2:0] s);
        case (s)
            3'd0:    return 5'b00001;
            3'd1:    return 5'b00011;
            3'd2:    return 5'b00111;
            3'd3:    return 5'b01111;
            3'd4:    return 5'b01111;
            3'd5:    return 5'b00110;
            3'd6:    return 5'b11111;
            default: return 5'b10111;
        endcase
    endfunction

`ifdef SEQ_FORCE_EN
    assign target = seq.force_en ? seq.force_scene : seq.songpos[7:5];
`else
    assign target = seq.songpos[7:5];
`endif
    assign unused_songpos = ^seq.songpos[4:0];

    assign fade_up    = {1'b0, fade_q} + STEP;
    assign fade_low   = {1'b0, fade_q} <= STEP;
    // A target change in RUN or FADE_IN starts dimming on the same frame
    assign fading_out = (state_q == FADE_OUT) || (state_q != SWITCH && target != scene_q);

    always_comb begin
        state_d  = state_q;
        scene_d  = scene_q;
        en_d     = en_q;
        fade_d   = fade_q;
        frames_d = frames_q;
        busy_d   = busy_q;
        if (seq.frame_start) begin
            frames_d = (frames_q == 8'hff) ? frames_q : frames_q + 8'd1;
            if (state_q == SWITCH) begin
                scene_d  = target;
                en_d     = scene_en(target);
                frames_d = 8'd0;
                state_d  = FADE_IN;
            end else if (fading_out) begin
                fade_d  = fade_low ? 6'd0 : fade_q - STEP[5:0];
                state_d = fade_low ? SWITCH : FADE_OUT;
            end else if (state_q == FADE_IN) begin
                fade_d  = (fade_up >= MAX) ? MAX[5:0] : fade_up[5:0];
                state_d = (fade_up >= MAX) ? RUN : FADE_IN;
            end
            busy_d = (state_d != RUN);
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FADE_IN;
            scene_q  <= 3'd0;
            en_q     <= 5'b00001;
            fade_q   <= 6'd0;
            frames_q <= 8'd0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            scene_q  <= scene_d;
            en_q     <= en_d;
            fade_q   <= fade_d;
            frames_q <= frames_d;
            busy_q   <= busy_d;
        end
    end

    assign seq.scene_id     = scene_q;
    assign seq.tileflash_en = en_q[4];
    assign seq.scope_en     = en_q[3];
    assign seq.plane_en     = en_q[2];
    assign seq.scroller_en  = en_q[1];
    assign seq.starfield_en = en_q[0];
    assign seq.fade_level   = fade_q;
    assign seq.scene_frames = frames_q;
    assign seq.busy         = busy_q;
endmodule
